noise_trigger_driver: RTL
=========================

Name: noise_trigger_driver

Overview:
- Drives the control side of the noise sound channel: noise clock enable, trigger and loud/soft select.
- Sits between the CPU sound-control write strobe and the noise sound block.
- Generates the pseudo-random noise clock from a 17-bit LFSR.
- Turns CPU register writes into a timed, retriggerable noise_en one-shot with a latched loud/soft level.

Parameters:
- PRESCALE, 3: number of clk_3MHz_en ticks per LFSR step. Legal range 1..255.
- HOLD_TICKS, 256: number of clk_3MHz_en ticks that noise_en stays high after a trigger. Legal range 1..65535.
- LFSR_SEED, 17'h1FFFF: LFSR value loaded at reset, and on lock-up recovery. Must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_3MHz_en  in  1  one-cycle tick enable at 3 MHz.
- wr  in  1  CPU write strobe to the sound-control register. Single clk cycle.
- data  in  8  CPU write data. Bit0 = trigger, bit1 = loud (1) / soft (0), bit7 = mute.
- noise_clk_en  out  1  one-clk pulse on each 0->1 transition of the LFSR output bit.
- noise_en  out  1  trigger one-shot, consumed by the noise sound block.
- loud_soft  out  1  level latched at trigger time.
- lfsr_bit  out  1  raw LFSR output bit, for debug and other sound channels.

Behaviour:
- Reset (asynchronous, rst_n = 0) sets:
  - lfsr = LFSR_SEED, prescale counter = 0, hold counter = 0.
  - Control register = 8'h00.
  - noise_clk_en = 0, noise_en = 0, loud_soft = 0, lfsr_bit = 1 (bit16 of the seed).
- Reset deassertion mid-operation discards any pending one-shot; nothing resumes after reset.
- LFSR:
  - 17 bits, Fibonacci form, polynomial x^17 + x^14 + 1.
  - On each step: new = {lfsr[15:0], lfsr[16] ^ lfsr[13]}.
  - lfsr_bit = lfsr[16].
  - A step occurs on the clk_3MHz_en tick at which the prescale counter equals PRESCALE-1; that same tick resets the counter to 0.
  - On every other clk_3MHz_en tick the prescale counter increments by 1.
  - If lfsr is ever all zeros, the next step loads LFSR_SEED instead of shifting.
- noise_clk_en:
  - Registered. High for exactly one clk cycle, the cycle after lfsr_bit goes 0->1.
  - Forced to 0 while control-register bit7 (mute) = 1. The LFSR keeps stepping while muted.
- Register write: when wr = 1, the control register loads data on that clk edge.
- Trigger detect:
  - Fires when wr = 1, data[0] = 1 and the previously stored register bit0 = 0 (rising edge of bit0).
  - Writing bit0 = 1 while bit0 is already 1 does not retrigger.
- One-shot states:
  - IDLE (noise_en = 0).
  - ACTIVE (noise_en = 1).
- Trigger in IDLE, on the clk edge after the wr cycle:
  - noise_en -> 1, loud_soft <- data[1].
  - Hold counter = HOLD_TICKS; state -> ACTIVE.
- ACTIVE:
  - The hold counter decrements on each clk_3MHz_en tick.
  - When it reaches 0, noise_en -> 0 on that same edge and state -> IDLE.
  - noise_en therefore stays high for exactly HOLD_TICKS ticks.
- Retrigger while ACTIVE: the counter reloads to HOLD_TICKS and loud_soft re-latches. noise_en stays 1 with no glitch.
- Simultaneous events:
  - A trigger in the same cycle as the counter expiry: trigger wins, noise_en stays 1.
  - wr coinciding with a clk_3MHz_en tick: the register updates and the LFSR steps independently.
- loud_soft holds its value in IDLE. It changes only on a trigger.
- Counter widths: $clog2(PRESCALE+1) and $clog2(HOLD_TICKS+1) bits, unsigned, no wrap below 0.
- Latency from wr to noise_en: 1 clk.

Decomposition:
- Shared sound package holds:
  - The control-bit index constants (TRIG_BIT = 0, LOUD_BIT = 1, MUTE_BIT = 7).
  - An enum for the one-shot state (IDLE, ACTIVE).
  - The LFSR polynomial tap constants (17, 14).
- One sub-module: noise_lfsr17, containing the prescaler, LFSR, lock-up recovery and rising-edge pulse.
- The one-shot and register logic stay in the top module.

Test Plan:
- Reset, then run 131071 LFSR steps -> lfsr returns to 17'h1FFFF exactly once. noise_clk_en pulse count equals the number of 0->1 transitions of lfsr_bit.
- Reset, PRESCALE = 3 -> the first LFSR step occurs on the 3rd clk_3MHz_en tick and lfsr becomes 17'h1FFFE.
- Write 8'h03 -> noise_en = 1 and loud_soft = 1 one clk later. noise_en falls after exactly 256 ticks.
- Write 8'h01, wait 100 ticks, write 8'h00, then 8'h01 -> noise_en stays high, loud_soft = 0, and falls 256 ticks after the second trigger (356 total). A write of 8'h01 while bit0 is already 1 causes no retrigger.
- Write 8'h80 -> noise_clk_en = 0 for 10000 ticks while lfsr_bit keeps toggling. Write 8'h00 -> pulses resume.
- Assert rst_n = 0 mid-ACTIVE at tick 50 -> all outputs drop to reset values immediately, asynchronously, and no noise_en appears after release.

Source files
------------

// File: rtl/noise_trigger_driver_pkg.sv
// Shared constants and types for the noise channel control path.
// Control-register bit positions, one-shot state encoding and the LFSR step function.
package noise_trigger_driver_pkg;

  localparam int TRIG_BIT = 0;
  localparam int LOUD_BIT = 1;
  localparam int MUTE_BIT = 7;

  localparam int LFSR_WIDTH  = 17;
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 14;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } oneShotState_t;

  // Fibonacci shift for x^17 + x^14 + 1; taps are 1-based polynomial exponents
  function automatic logic [LFSR_WIDTH-1:0] lfsrStep(input logic [LFSR_WIDTH-1:0] cur);
    return {cur[LFSR_WIDTH-2:0], cur[LFSR_TAP_HI-1] ^ cur[LFSR_TAP_LO-1]};
  endfunction

endpackage

// File: rtl/noise_lfsr17.sv
// Prescaled 17-bit noise LFSR with lock-up recovery and a registered
// rising-edge pulse on its output bit, suppressible by mute.
module noise_lfsr17
  import noise_trigger_driver_pkg::*;
#(
  parameter int                    PRESCALE  = 3,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 17'h1FFFF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_mute,
  output logic o_lfsrBit,
  output logic o_clkEn
);

  localparam int              PS_W    = $clog2(PRESCALE + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]       r_prescaleCnt;
  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic                  r_prevBit;
  logic                  r_clkEn;
  logic                  w_step;
  logic                  w_rise;

  assign w_step = i_tick && (r_prescaleCnt == PS_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prescaleCnt <= '0;
    end else if (i_tick) begin
      if (w_step) r_prescaleCnt <= '0;
      else        r_prescaleCnt <= r_prescaleCnt + PS_W'(1);
    end
  end

  // An all-zero register can never leave zero, so reseed instead of shifting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_step) begin
      if (r_lfsr == '0) r_lfsr <= LFSR_SEED;
      else              r_lfsr <= lfsrStep(r_lfsr);
    end
  end

  assign w_rise = r_lfsr[LFSR_WIDTH-1] & ~r_prevBit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prevBit <= LFSR_SEED[LFSR_WIDTH-1];
      r_clkEn   <= 1'b0;
    end else begin
      r_prevBit <= r_lfsr[LFSR_WIDTH-1];
      r_clkEn   <= w_rise & ~i_mute;
    end
  end

  assign o_lfsrBit = r_lfsr[LFSR_WIDTH-1];
  assign o_clkEn   = r_clkEn;

endmodule

// File: rtl/noise_trigger_driver.sv
// Noise channel control: CPU control register, retriggerable noise_en
// one-shot with latched loud/soft level, and the LFSR noise clock.
module noise_trigger_driver
  import noise_trigger_driver_pkg::*;
#(
  parameter int                    PRESCALE   = 3,
  parameter int                    HOLD_TICKS = 256,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 17'h1FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_3MHz_en,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       noise_clk_en,
  output logic       noise_en,
  output logic       loud_soft,
  output logic       lfsr_bit
);

  localparam int                HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  logic [7:0]        r_ctrl;
  oneShotState_t     r_state;
  oneShotState_t     w_nextState;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_nextHold;
  logic              r_loud;
  logic              w_nextLoud;
  logic              w_trig;
  logic              w_unusedCtrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_ctrl <= 8'h00;
    else if (wr) r_ctrl <= data;
  end

  // Only a 0->1 change of the stored trigger bit starts or restarts the one-shot
  assign w_trig = wr & data[TRIG_BIT] & ~r_ctrl[TRIG_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_loud  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_hold  <= w_nextHold;
      r_loud  <= w_nextLoud;
    end
  end

  // A trigger outranks expiry, so a coincident trigger keeps noise_en high
  always_comb begin
    w_nextState = r_state;
    w_nextHold  = r_hold;
    w_nextLoud  = r_loud;
    if (w_trig) begin
      w_nextState = ACTIVE;
      w_nextHold  = HOLD_LOAD;
      w_nextLoud  = data[LOUD_BIT];
    end else begin
      case (r_state)
        ACTIVE: begin
          if (clk_3MHz_en) begin
            if (r_hold <= HOLD_W'(1)) begin
              w_nextHold  = '0;
              w_nextState = IDLE;
            end else begin
              w_nextHold  = r_hold - HOLD_W'(1);
            end
          end
        end
        default: begin
          w_nextState = IDLE;
        end
      endcase
    end
  end

  noise_lfsr17 #(
    .PRESCALE  (PRESCALE),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tick    (clk_3MHz_en),
    .i_mute    (r_ctrl[MUTE_BIT]),
    .o_lfsrBit (lfsr_bit),
    .o_clkEn   (noise_clk_en)
  );

  assign noise_en  = (r_state == ACTIVE);
  assign loud_soft = r_loud;

  assign w_unusedCtrl = ^r_ctrl[6:1];

endmodule
